vga_overlay_mixer: RTL and testbench

//  Next-generation VGA pixel mixer. Sits between the bit-plane line memories and the VGA pins.

---
 rtl/vga_overlay_mixer.sv | 210 +++++++++++++++++++++
 tb/tb_vga_overlay_mixer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_overlay_mixer.sv
// VGA pixel mixer: maps bit-plane pixels to RGB under a frame-shadowed colour mode and
// overlays a blinking crosshair cursor; sync and DE are delayed to match the 2-stage pixel path.
module vga_overlay_mixer #(
  parameter int ADDR_WIDTH   = 11,
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int PIXEL_WIDTH  = 8,
  parameter int NPLANES      = 5,
  parameter int CURSOR_HALF  = 1,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                   VCLK,
  input  logic                   RST,
  input  logic                   iVSYNC,
  input  logic                   iHSYNC,
  input  logic                   iDE,
  input  logic [ADDR_WIDTH-1:0]  iH_ADDR,
  input  logic [ADDR_WIDTH-1:0]  iV_ADDR,
  input  logic [NPLANES-1:0]     iPIX,
  input  logic [1:0]             iMODE,
  input  logic                   iCURSOR_EN,
  input  logic                   iBLINK_EN,
  input  logic [ADDR_WIDTH-1:0]  iPOINT_X,
  input  logic [ADDR_WIDTH-1:0]  iPOINT_Y,
  output logic                   oVGA_HSYNC,
  output logic                   oVGA_VSYNC,
  output logic                   oVGA_DE,
  output logic [PIXEL_WIDTH-1:0] oVGA_R,
  output logic [PIXEL_WIDTH-1:0] oVGA_G,
  output logic [PIXEL_WIDTH-1:0] oVGA_B,
  output logic                   oFRAME_TICK
);

  typedef enum logic [1:0] {
    MODE_MONO   = 2'd0,
    MODE_PACKED = 2'd1,
    MODE_TINT   = 2'd2,
    MODE_BORDER = 2'd3
  } mode_e;

  localparam int                    CNT_W    = $clog2(2 * BLINK_FRAMES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(2 * BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0]      CNT_ON   = CNT_W'(BLINK_FRAMES);
  localparam logic [ADDR_WIDTH:0]   HALF     = (ADDR_WIDTH + 1)'(CURSOR_HALF);
  localparam logic [ADDR_WIDTH-1:0] H_LAST   = ADDR_WIDTH'(HACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] V_LAST   = ADDR_WIDTH'(VACTIVE - 1);

  // Frame-shadowed controls
  mode_e                   mode_q, mode_d;
  logic                    cursor_en_q, cursor_en_d;
  logic                    blink_en_q, blink_en_d;
  logic [ADDR_WIDTH-1:0]   px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    vs_prev_q, vs_prev_d;
  logic                    frame_tick_q, frame_tick_d;

  // Stage 1
  logic [NPLANES-1:0]      pix_s1_q, pix_s1_d;
  mode_e                   mode_s1_q, mode_s1_d;
  logic                    de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic                    border_s1_q, border_s1_d, hit_s1_q, hit_s1_d;

  // Stage 2
  logic [PIXEL_WIDTH-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic                    de_s2_q, de_s2_d, hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;

  logic                    frame_start;
  logic                    visible;
  logic [PIXEL_WIDTH-1:0]  packed_pix;

  // Plane 1 lands in the MSB, plane 0 right after the last plane, zeros below.
  function automatic logic [PIXEL_WIDTH-1:0] packed_colour(input logic [NPLANES-1:0] p);
    logic [PIXEL_WIDTH-1:0] c;
    c = '0;
    for (int i = 1; i < NPLANES; i++) c[PIXEL_WIDTH-i] = p[i];
    c[PIXEL_WIDTH-NPLANES] = p[0];
    return c;
  endfunction

  // Signed one-bit-wider difference so the arm never wraps around the screen edge.
  function automatic logic near(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    logic signed [ADDR_WIDTH:0] diff;
    logic        [ADDR_WIDTH:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[ADDR_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    return mag <= HALF;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    frame_start  = iVSYNC & ~vs_prev_q;
    mode_d       = mode_q;
    cursor_en_d  = cursor_en_q;
    blink_en_d   = blink_en_q;
    px_d         = px_q;
    py_d         = py_q;
    blink_cnt_d  = blink_cnt_q;
    vs_prev_d    = iVSYNC;
    frame_tick_d = frame_start;

    if (frame_start) begin
      mode_d      = mode_e'(iMODE);
      cursor_en_d = iCURSOR_EN;
      blink_en_d  = iBLINK_EN;
      px_d        = iPOINT_X;
      py_d        = iPOINT_Y;
      blink_cnt_d = (blink_cnt_q == CNT_LAST) ? '0 : blink_cnt_q + CNT_W'(1);
    end

    visible     = ~blink_en_q | (blink_cnt_q < CNT_ON);
    pix_s1_d    = iPIX;
    mode_s1_d   = mode_q;
    de_s1_d     = iDE;
    hs_s1_d     = iHSYNC;
    vs_s1_d     = iVSYNC;
    border_s1_d = (iH_ADDR == '0) | (iH_ADDR == H_LAST) | (iV_ADDR == '0) | (iV_ADDR == V_LAST);
    hit_s1_d    = iDE & cursor_en_q & visible & (near(iH_ADDR, px_q) | near(iV_ADDR, py_q));

    packed_pix = packed_colour(pix_s1_q);
    r_d        = '0;
    g_d        = '0;
    b_d        = '0;
    if (de_s1_q) begin
      if (hit_s1_q) begin
        r_d = '1;
      end else begin
        case (mode_s1_q)
          MODE_MONO: begin
            r_d[PIXEL_WIDTH-1] = pix_s1_q[0];
            r_d[PIXEL_WIDTH-2] = pix_s1_q[0];
            g_d = r_d;
            b_d = r_d;
          end
          MODE_PACKED: begin
            r_d = packed_pix;
            g_d = packed_pix;
            b_d = packed_pix;
          end
          MODE_TINT: r_d = {PIXEL_WIDTH{pix_s1_q[0]}};
          MODE_BORDER: begin
            r_d = border_s1_q ? '1 : packed_pix;
            g_d = r_d;
            b_d = r_d;
          end
        endcase
      end
    end
    de_s2_d = de_s1_q;
    hs_s2_d = hs_s1_q;
    vs_s2_d = vs_s1_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      mode_q       <= MODE_MONO;
      cursor_en_q  <= 1'b0;
      blink_en_q   <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      blink_cnt_q  <= '0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      pix_s1_q     <= '0;
      mode_s1_q    <= MODE_MONO;
      de_s1_q      <= 1'b0;
      hs_s1_q      <= 1'b0;
      vs_s1_q      <= 1'b0;
      border_s1_q  <= 1'b0;
      hit_s1_q     <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      de_s2_q      <= 1'b0;
      hs_s2_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cursor_en_q  <= cursor_en_d;
      blink_en_q   <= blink_en_d;
      px_q         <= px_d;
      py_q         <= py_d;
      blink_cnt_q  <= blink_cnt_d;
      vs_prev_q    <= vs_prev_d;
      frame_tick_q <= frame_tick_d;
      pix_s1_q     <= pix_s1_d;
      mode_s1_q    <= mode_s1_d;
      de_s1_q      <= de_s1_d;
      hs_s1_q      <= hs_s1_d;
      vs_s1_q      <= vs_s1_d;
      border_s1_q  <= border_s1_d;
      hit_s1_q     <= hit_s1_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      de_s2_q      <= de_s2_d;
      hs_s2_q      <= hs_s2_d;
      vs_s2_q      <= vs_s2_d;
    end
  end

  assign oVGA_HSYNC  = hs_s2_q;
  assign oVGA_VSYNC  = vs_s2_q;
  assign oVGA_DE     = de_s2_q;
  assign oVGA_R      = r_q;
  assign oVGA_G      = g_q;
  assign oVGA_B      = b_q;
  assign oFRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_vga_overlay_mixer.sv
// Bench for vga_overlay_mixer: randomized pixels checked against an arithmetic model of the
// mixer's colour/cursor/shadow rules, with a 2-deep queue of expected outputs.
module tb_vga_overlay_mixer;

  localparam int AW = 11, PW = 8, NP = 5, HA = 640, VA = 480, HALF = 1, BF = 2;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [PW-1:0] r;
    logic [PW-1:0] g;
    logic [PW-1:0] b;
  } vga_t;

  logic          VCLK = 1'b0;
  logic          RST;
  logic          iVSYNC, iHSYNC, iDE, iCURSOR_EN, iBLINK_EN;
  logic [AW-1:0] iH_ADDR, iV_ADDR, iPOINT_X, iPOINT_Y;
  logic [NP-1:0] iPIX;
  logic [1:0]    iMODE;
  logic          oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oFRAME_TICK;
  logic [PW-1:0] oVGA_R, oVGA_G, oVGA_B;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   m_mode, m_px, m_py, m_frames;
  bit   m_cur, m_blink, m_vs_prev;
  vga_t exp_q[$];

  vga_overlay_mixer #(
    .ADDR_WIDTH(AW), .HACTIVE(HA), .VACTIVE(VA), .PIXEL_WIDTH(PW),
    .NPLANES(NP), .CURSOR_HALF(HALF), .BLINK_FRAMES(BF)
  ) dut (
    .VCLK(VCLK), .RST(RST), .iVSYNC(iVSYNC), .iHSYNC(iHSYNC), .iDE(iDE),
    .iH_ADDR(iH_ADDR), .iV_ADDR(iV_ADDR), .iPIX(iPIX), .iMODE(iMODE),
    .iCURSOR_EN(iCURSOR_EN), .iBLINK_EN(iBLINK_EN),
    .iPOINT_X(iPOINT_X), .iPOINT_Y(iPOINT_Y),
    .oVGA_HSYNC(oVGA_HSYNC), .oVGA_VSYNC(oVGA_VSYNC), .oVGA_DE(oVGA_DE),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B), .oFRAME_TICK(oFRAME_TICK)
  );

  always #5 VCLK = ~VCLK;

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic vga_t model_pixel(int h, int v, logic [NP-1:0] p, logic de);
    vga_t e;
    int   val;
    bit   vis, hit, border;
    e = '0;
    if (!de) return e;
    vis = !m_blink || ((m_frames % (2 * BF)) < BF);
    hit = m_cur && vis && (iabs(h - m_px) <= HALF || iabs(v - m_py) <= HALF);
    if (hit) begin
      e.r = 8'hFF;
      return e;
    end
    val = 0;
    for (int i = 1; i < NP; i++) val = val * 2 + int'(p[i]);
    val = (val * 2 + int'(p[0])) << (PW - NP);
    border = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
    case (m_mode)
      0: begin e.r = p[0] ? 8'hC0 : 8'h00; e.g = e.r; e.b = e.r; end
      1: begin e.r = 8'(val); e.g = e.r; e.b = e.r; end
      2: e.r = p[0] ? 8'hFF : 8'h00;
      default: begin e.r = border ? 8'hFF : 8'(val); e.g = e.r; e.b = e.r; end
    endcase
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_px = 0; m_py = 0; m_frames = 0;
    m_cur = 0; m_blink = 0; m_vs_prev = 0;
  endtask

  // Advance one clock; return the output that is due now and what the model expects of it.
  task automatic tick(output logic chk, output vga_t got, output vga_t exp,
                      output logic got_ft, output logic exp_ft);
    vga_t e;
    bit   fs;
    e    = model_pixel(int'(iH_ADDR), int'(iV_ADDR), iPIX, iDE);
    e.hs = iHSYNC;
    e.vs = iVSYNC;
    e.de = iDE;
    exp_q.push_back(e);
    fs = iVSYNC && !m_vs_prev;
    if (fs) begin
      m_mode  = int'(iMODE);
      m_cur   = iCURSOR_EN;
      m_blink = iBLINK_EN;
      m_px    = int'(iPOINT_X);
      m_py    = int'(iPOINT_Y);
      m_frames++;
    end
    m_vs_prev = iVSYNC;
    @(posedge VCLK);
    #1;
    got    = {oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oVGA_R, oVGA_G, oVGA_B};
    got_ft = oFRAME_TICK;
    exp_ft = fs;
    chk    = (exp_q.size() == 2);
    exp    = chk ? exp_q.pop_front() : '0;
  endtask

  task automatic set_pix(int h, int v, logic [NP-1:0] p, logic de);
    iH_ADDR = AW'(h);
    iV_ADDR = AW'(v);
    iPIX    = p;
    iDE     = de;
    iHSYNC  = 1'($urandom_range(0, 1));
  endtask

  task automatic new_frame(int mode, bit cur, bit blink, int px, int py);
    logic c, gf, ef;
    vga_t g, e;
    iMODE = 2'(mode); iCURSOR_EN = cur; iBLINK_EN = blink;
    iPOINT_X = AW'(px); iPOINT_Y = AW'(py);
    iDE = 1'b0; iVSYNC = 1'b1;
    tick(c, g, e, gf, ef);
    iVSYNC = 1'b0;
    tick(c, g, e, gf, ef);
  endtask

  task automatic test_reset();
    logic c, gf, ef;
    vga_t g, e;
    new_frame(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      set_pix(10 + i, 10, 5'h1F, 1'b1);
      iHSYNC = 1'b1;
      tick(c, g, e, gf, ef);
      if (c) begin
        total++;
        if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL pre_reset got=%h/%b exp=%h/%b", g, gf, e, ef); end
      end
    end
    #3 RST = 1'b1;
    #1;
    total++;
    if ({oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oVGA_R, oVGA_G, oVGA_B, oFRAME_TICK} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b%b%b %h %h %h %b exp=all zero",
               oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oVGA_R, oVGA_G, oVGA_B, oFRAME_TICK);
    end
    iVSYNC = 1'b0;
    model_reset();
    @(posedge VCLK);
    #1 RST = 1'b0;
    iMODE = 2'd2;
    for (int i = 0; i < 6; i++) begin
      set_pix(20 + i, 30, NP'($urandom), 1'b1);
      tick(c, g, e, gf, ef);
      if (c) begin
        total++;
        if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL post_reset_mode got=%h/%b exp=%h/%b", g, gf, e, ef); end
      end
    end
  endtask

  task automatic test_mono();
    logic c, gf, ef;
    vga_t g, e;
    new_frame(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: set_pix(1, 1, 5'b00001, 1'b1);
        1: set_pix(2, 1, 5'b00001, 1'b0);
        2: set_pix(3, 1, 5'b11110, 1'b1);
        default: set_pix($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), NP'($urandom), 1'($urandom));
      endcase
      tick(c, g, e, gf, ef);
      if (c) begin
        total++;
        if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL mono got=%h/%b exp=%h/%b", g, gf, e, ef); end
      end
    end
  endtask

  task automatic test_cursor();
    logic c, gf, ef;
    vga_t g, e;
    int   rows[5] = '{10, 49, 50, 51, 52};
    new_frame(1, 1, 0, 100, 50);
    foreach (rows[r]) begin
      for (int h = 97; h <= 103; h++) begin
        set_pix(h, rows[r], NP'($urandom), 1'b1);
        tick(c, g, e, gf, ef);
        if (c) begin
          total++;
          if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL cursor h=%0d got=%h/%b exp=%h/%b", h, g, gf, e, ef); end
        end
      end
      set_pix(300, rows[r], NP'($urandom), 1'b1);
      tick(c, g, e, gf, ef);
      if (c) begin
        total++;
        if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL cursor_row got=%h/%b exp=%h/%b", g, gf, e, ef); end
      end
    end
  endtask

  task automatic test_corner();
    logic c, gf, ef;
    vga_t g, e;
    int   hs[6] = '{0, 1, 2, 638, 639, 320};
    int   vs[6] = '{0, 1, 2, 478, 479, 240};
    for (int m = 0; m < 4; m += 3) begin
      new_frame(m, 1, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
        if (i < 6) set_pix(hs[i], 200, 5'b00011, 1'b1);
        else       set_pix(300, vs[i - 6], 5'b00011, 1'b1);
        tick(c, g, e, gf, ef);
        if (c) begin
          total++;
          if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL corner m=%0d got=%h/%b exp=%h/%b", m, g, gf, e, ef); end
        end
      end
    end
  endtask

  task automatic test_blink();
    logic c, gf, ef;
    vga_t g, e;
    int   ticks;
    iMODE = 2'd0; iCURSOR_EN = 1'b1; iBLINK_EN = 1'b1;
    iPOINT_X = AW'(5); iPOINT_Y = AW'(5);
    for (int f = 0; f < 6; f++) begin
      ticks = 0;
      for (int s = 0; s < 8; s++) begin
        iVSYNC = (s < 2);
        case (s)
          3: set_pix(5, 5, 5'b00001, 1'b1);
          4: set_pix(5, 300, 5'b00000, 1'b1);
          5: set_pix(300, 300, 5'b00001, 1'b1);
          default: set_pix(0, 0, 5'b00000, 1'b0);
        endcase
        tick(c, g, e, gf, ef);
        ticks += int'(gf);
        if (c) begin
          total++;
          if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL blink f=%0d s=%0d got=%h/%b exp=%h/%b", f, s, g, gf, e, ef); end
        end
      end
      total++;
      if (ticks !== 1) begin bad++; $display("FAIL frame_tick_count f=%0d got=%0d exp=1", f, ticks); end
    end
  endtask

  task automatic test_shadow();
    logic c, gf, ef;
    vga_t g, e;
    new_frame(0, 1, 0, 100, 50);
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 1) begin iPOINT_X = AW'(200); iMODE = 2'd2; end
      if (pass == 2) new_frame(2, 1, 0, 200, 50);
      for (int i = 0; i < 8; i++) begin
        set_pix((i < 4) ? 99 + i : 198 + i - 4, 10, 5'b00001, 1'b1);
        tick(c, g, e, gf, ef);
        if (c) begin
          total++;
          if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL shadow p=%0d got=%h/%b exp=%h/%b", pass, g, gf, e, ef); end
        end
      end
    end
  endtask

  task automatic test_random();
    logic c, gf, ef;
    vga_t g, e;
    int   h, v;
    for (int i = 0; i < 600; i++) begin
      iVSYNC     = ($urandom_range(0, 19) == 0);
      iMODE      = 2'($urandom);
      iCURSOR_EN = ($urandom_range(0, 3) != 0);
      iBLINK_EN  = 1'($urandom);
      iPOINT_X   = AW'($urandom_range(0, HA - 1));
      iPOINT_Y   = AW'($urandom_range(0, VA - 1));
      h = $urandom_range(0, 1) ? m_px + $urandom_range(0, 4) - 2 : $urandom_range(0, HA - 1);
      v = $urandom_range(0, 1) ? m_py + $urandom_range(0, 4) - 2 : $urandom_range(0, VA - 1);
      h = (h < 0) ? 0 : (h > HA - 1) ? HA - 1 : h;
      v = (v < 0) ? 0 : (v > VA - 1) ? VA - 1 : v;
      set_pix(h, v, NP'($urandom), ($urandom_range(0, 3) != 0));
      tick(c, g, e, gf, ef);
      if (c) begin
        total++;
        if ({g, gf} !== {e, ef}) begin bad++; $display("FAIL random i=%0d got=%h/%b exp=%h/%b", i, g, gf, e, ef); end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    iVSYNC = 1'b0; iHSYNC = 1'b0; iDE = 1'b0;
    iH_ADDR = '0; iV_ADDR = '0; iPIX = '0; iMODE = '0;
    iCURSOR_EN = 1'b0; iBLINK_EN = 1'b0; iPOINT_X = '0; iPOINT_Y = '0;
    model_reset();
    repeat (3) @(posedge VCLK);
    #1;
    total++;
    if ({oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oVGA_R, oVGA_G, oVGA_B, oFRAME_TICK} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b%b%b %h %h %h %b exp=all zero",
               oVGA_HSYNC, oVGA_VSYNC, oVGA_DE, oVGA_R, oVGA_G, oVGA_B, oFRAME_TICK);
    end
    RST = 1'b0;
    test_reset();
    test_mono();
    test_cursor();
    test_corner();
    test_blink();
    test_shadow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
